// File: rtl/uart_rx_core.sv
// UART receiver: oversampled start detection, LSB-first deserializer, optional parity and stop check.
// Optional build macro UART_RX_MAJORITY_VOTE_EN selects 3-sample majority voting per bit.
//
// state    | meaning
// ---------|--------------------------------------------------------------
// S_IDLE   | line idle; first low cycle latches config and starts a frame
// S_START  | start bit; a high sample aborts the frame as a glitch
// S_DATA   | DATA_WIDTH payload bits shifted in LSB-first
// S_PARITY | parity bit compared, mismatch remembered until frame end
// S_STOP   | stop bit; strobes registered on its last edge
module uart_rx_core #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                  state_q, state_d;
  logic [PRESC_W-1:0]      edge_cnt_q, edge_cnt_d;
  logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [PRESC_W-1:0]      presc_q, presc_d;
  logic                    par_en_q, par_en_d;
  logic                    par_typ_q, par_typ_d;
  logic                    par_bad_q, par_bad_d;
  logic                    stop_bad_q, stop_bad_d;
  logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
  logic                    data_valid_q, data_valid_d;
  logic                    par_err_q, par_err_d;
  logic                    stp_err_q, stp_err_d;

  logic [PRESC_W-1:0]      mid;
  logic [PRESC_W-1:0]      last;
  logic                    bit_end;
  logic                    samp_fire;
  logic                    samp_bit;
  logic                    early_abort;

  assign mid     = presc_q >> 1;
  assign last    = presc_q - PRESC_W'(1);
  assign bit_end = (edge_cnt_q == last);

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0]         maj_q, maj_d;
  logic [PRESC_W-1:0] mid_m1;
  logic [PRESC_W-1:0] mid_p1;

  assign mid_m1 = mid - PRESC_W'(1);
  assign mid_p1 = mid + PRESC_W'(1);

  always_comb begin
    maj_d = maj_q;
    if (edge_cnt_q == mid_m1) maj_d[0] = RX_IN;
    if (edge_cnt_q == mid)    maj_d[1] = RX_IN;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) maj_q <= '0;
    else      maj_q <= maj_d;
  end

  // Vote resolves on the third sample; two early highs already decide a start glitch.
  assign samp_fire   = (edge_cnt_q == mid_p1);
  assign samp_bit    = (maj_q[0] & maj_q[1]) | (maj_q[0] & RX_IN) | (maj_q[1] & RX_IN);
  assign early_abort = (edge_cnt_q == mid) & maj_q[0] & RX_IN;
`else
  assign samp_fire   = (edge_cnt_q == mid);
  assign samp_bit    = RX_IN;
  assign early_abort = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    edge_cnt_d   = edge_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    presc_d      = presc_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    par_bad_d    = par_bad_q;
    stop_bad_d   = stop_bad_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;

    if (state_q != S_IDLE) edge_cnt_d = bit_end ? '0 : edge_cnt_q + PRESC_W'(1);

    case (state_q)
      S_IDLE: begin
        // The detecting cycle is edge 0 of the start bit, so the next cycle is edge 1.
        if (!RX_IN) begin
          state_d    = S_START;
          edge_cnt_d = PRESC_W'(1);
          bit_cnt_d  = '0;
          presc_d    = Prescale;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          par_bad_d  = 1'b0;
          stop_bad_d = 1'b0;
        end
      end
      S_START: begin
        if (early_abort || (samp_fire && samp_bit)) begin
          state_d    = S_IDLE;
          edge_cnt_d = '0;
        end else if (bit_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (samp_fire) shift_d = {samp_bit, shift_q[DATA_WIDTH-1:1]};
        if (bit_end) begin
          if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      S_PARITY: begin
        if (samp_fire) par_bad_d = (samp_bit != ((^shift_q) ^ par_typ_q));
        if (bit_end)   state_d = S_STOP;
      end
      S_STOP: begin
        if (samp_fire) stop_bad_d = !samp_bit;
        if (bit_end) begin
          state_d = S_IDLE;
          if (par_bad_q || stop_bad_q) begin
            par_err_d = par_bad_q;
            stp_err_d = stop_bad_q;
          end else begin
            data_valid_d = 1'b1;
            p_data_d     = shift_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      presc_q      <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_bad_q    <= 1'b0;
      stop_bad_q   <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      presc_q      <= presc_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      par_bad_q    <= par_bad_d;
      stop_bad_q   <= stop_bad_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;

endmodule
